divider: RTL

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 121 ++++++++++++
 1 files changed

// File: rtl/divider.sv
// Signed restoring divider, one quotient bit per cycle.
// Truncating division with a divide-by-zero flag.
module divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             op_done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] qsh;
    logic [WIDTH-1:0] dmag;
    logic [WIDTH-1:0] dvd;
    logic             sgn_a;
    logic             sgn_b;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] prem_nxt;
    logic [WIDTH-1:0] qsh_nxt;
    logic             dz;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    assign op_done = (state == S_DONE);

    // Operand magnitudes; the most negative value maps to unsigned 2^(W-1).
    always_comb begin
        a_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        b_mag = divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor;
    end

    // One restoring step plus the sign-corrected final result.
    always_comb begin
        shifted  = {prem, qsh[WIDTH-1]};
        diff     = shifted - {1'b0, dmag};
        take     = ~diff[WIDTH];
        prem_nxt = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        qsh_nxt  = {qsh[WIDTH-2:0], take};
        dz       = (dmag == '0);
        q_fin    = (sgn_a ^ sgn_b) ? (~qsh_nxt + 1'b1) : qsh_nxt;
        r_fin    = sgn_a ? (~prem_nxt + 1'b1) : prem_nxt;
        if (dz) begin
            q_fin = '1;
            r_fin = dvd;
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            count       <= '0;
            prem        <= '0;
            qsh         <= '0;
            dmag        <= '0;
            dvd         <= '0;
            sgn_a       <= 1'b0;
            sgn_b       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (op_clear) begin
            state       <= S_IDLE;
            count       <= '0;
            prem        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_start) begin
                        dvd   <= dividend;
                        qsh   <= a_mag;
                        dmag  <= b_mag;
                        sgn_a <= dividend[WIDTH-1];
                        sgn_b <= divisor[WIDTH-1];
                        prem  <= '0;
                        count <= '0;
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    prem  <= prem_nxt;
                    qsh   <= qsh_nxt;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        quotient    <= q_fin;
                        remainder   <= r_fin;
                        div_by_zero <= dz;
                        state       <= S_DONE;
                    end
                end
                S_DONE: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
